// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one request at a time, lane placement, write masks and load extension.
// Optional MISALIGNED_SPLIT_EN: accesses crossing an NB boundary are issued as two aligned beats.
module load_store_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_store,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_rsp_valid,
  output logic              o_rsp_err,
  output logic [XLEN-1:0]   o_rsp_rdata,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_wmask,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);
  localparam int SHW = OFS + 3;
`ifdef MISALIGNED_SPLIT_EN
  localparam int SPAN = 2;
`else
  localparam int SPAN = 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT0,
`ifdef MISALIGNED_SPLIT_EN
    S_BEAT1,
`endif
    S_RESP
  } state_t;

  state_t          r_state;
  logic            r_store;
  logic [2:0]      r_funct3;
  logic [OFS-1:0]  r_off;

  logic [OFS-1:0]       w_off;
  logic [3:0]           w_size;
  logic                 w_illegal;
  logic                 w_err_req;
  logic                 w_last_beat;
  logic [SPAN*XLEN-1:0] w_wdata_sh;
  logic [SPAN*NB-1:0]   w_size_ones;
  logic [SPAN*NB-1:0]   w_wmask_sh;
  logic [SPAN*XLEN-1:0] w_rd_pair;
  logic [XLEN-1:0]      w_field;
  logic [6:0]           w_nbits;
  logic [XLEN-1:0]      w_keep;
  logic [SHW-1:0]       w_sign_idx;
  logic                 w_sign;
  logic [XLEN-1:0]      w_ext;

  assign w_off  = i_req_addr[OFS-1:0];
  assign w_size = 4'd1 << i_req_funct3[1:0];

  always_comb begin
    w_illegal = i_req_store ? i_req_funct3[2] : (i_req_funct3 == 3'b111);
    if (XLEN == 32 && (i_req_funct3[1:0] == 2'b11 || i_req_funct3 == 3'b110))
      w_illegal = 1'b1;
  end

`ifdef MISALIGNED_SPLIT_EN
  logic            r_split;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_wdata_hi;
  logic [NB-1:0]   r_wmask_hi;
  logic [4:0]      w_end;
  logic            w_split;

  assign w_end       = 5'(w_off) + 5'(w_size);
  assign w_split     = w_end > 5'(NB);
  assign w_err_req   = w_illegal;
  assign w_last_beat = (r_state == S_BEAT1) || !r_split;
  assign w_rd_pair   = (r_state == S_BEAT1) ? {i_mem_rdata, r_lo} : {{XLEN{1'b0}}, i_mem_rdata};
`else
  logic w_misalign;

  assign w_misalign  = (4'(w_off) & (w_size - 4'd1)) != 4'd0;
  assign w_err_req   = w_illegal | w_misalign;
  assign w_last_beat = 1'b1;
  assign w_rd_pair   = i_mem_rdata;
`endif

  // Store data and mask are shifted into a (possibly two-beat) lane window once, at accept time.
  assign w_wdata_sh  = (SPAN*XLEN)'(i_req_wdata) << {w_off, 3'b000};
  assign w_size_ones = ~({(SPAN*NB){1'b1}} << w_size);
  assign w_wmask_sh  = w_size_ones << w_off;

  assign w_field    = XLEN'(w_rd_pair >> {r_off, 3'b000});
  assign w_nbits    = 7'd8 << r_funct3[1:0];
  assign w_keep     = ~({XLEN{1'b1}} << w_nbits);
  assign w_sign_idx = SHW'(w_nbits - 7'd1);
  assign w_sign     = ~r_funct3[2] & w_field[w_sign_idx];
  assign w_ext      = (w_field & w_keep) | (~w_keep & {XLEN{w_sign}});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_store     <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= '0;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= '0;
      o_mem_valid <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wmask <= '0;
`ifdef MISALIGNED_SPLIT_EN
      r_split     <= 1'b0;
      r_lo        <= '0;
      r_wdata_hi  <= '0;
      r_wmask_hi  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            o_req_ready <= 1'b0;
            r_store     <= i_req_store;
            r_funct3    <= i_req_funct3;
            r_off       <= w_off;
            if (w_err_req) begin
              r_state     <= S_RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= '0;
            end else begin
              r_state     <= S_BEAT0;
              o_mem_valid <= 1'b1;
              o_mem_we    <= i_req_store;
              o_mem_addr  <= {i_req_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
              o_mem_wdata <= w_wdata_sh[XLEN-1:0];
              o_mem_wmask <= i_req_store ? w_wmask_sh[NB-1:0] : '0;
`ifdef MISALIGNED_SPLIT_EN
              r_split     <= w_split;
              r_wdata_hi  <= w_wdata_sh[2*XLEN-1:XLEN];
              r_wmask_hi  <= i_req_store ? w_wmask_sh[2*NB-1:NB] : '0;
`endif
            end
          end
        end
`ifdef MISALIGNED_SPLIT_EN
        S_BEAT0, S_BEAT1: begin
`else
        S_BEAT0: begin
`endif
          if (i_mem_ready) begin
            if (w_last_beat) begin
              r_state     <= S_RESP;
              o_mem_valid <= 1'b0;
              o_mem_we    <= 1'b0;
              o_mem_wmask <= '0;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b0;
              o_rsp_rdata <= r_store ? '0 : w_ext;
            end
`ifdef MISALIGNED_SPLIT_EN
            else begin
              r_state     <= S_BEAT1;
              r_lo        <= i_mem_rdata;
              o_mem_addr  <= o_mem_addr + ADDR_W'(NB);
              o_mem_wdata <= r_wdata_hi;
              o_mem_wmask <= r_wmask_hi;
            end
`endif
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          o_req_ready <= 1'b1;
          o_rsp_valid <= 1'b0;
          o_rsp_err   <= 1'b0;
          o_rsp_rdata <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=32); a small memory responder serves beats with optional stalls.
// Expectations for misaligned cases follow MISALIGNED_SPLIT_EN when it is defined for the build.
module tb_load_store_unit;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;
  localparam int NB     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [XLEN-1:0]   rsp_rdata;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [NB-1:0]     mem_wmask;
  logic [XLEN-1:0]   mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_store  (req_store),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_err    (rsp_err),
    .o_rsp_rdata  (rsp_rdata),
    .o_mem_valid  (mem_valid),
    .i_mem_ready  (mem_ready),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_wmask  (mem_wmask),
    .i_mem_rdata  (mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          t_beats;
  int          t_rsp_cyc;
  int          t_unstable;
  logic        t_err;
  logic [31:0] t_rdata;
  logic [31:0] t_addr [2];
  logic [31:0] t_wdata[2];
  logic [3:0]  t_wmask[2];
  logic        t_we   [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request at a negedge and plays memory until the response or a 20-cycle budget.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd0, input logic [31:0] rd1,
                         input int stall);
    int          stall_left;
    logic        prev_stall;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wmask;
    logic        p_we;
    t_beats = 0; t_rsp_cyc = -1; t_unstable = 0; t_err = 1'b0; t_rdata = '0;
    for (int b = 0; b < 2; b++) begin
      t_addr[b] = '0; t_wdata[b] = '0; t_wmask[b] = '0; t_we[b] = 1'b0;
    end
    stall_left = stall; prev_stall = 1'b0;
    p_addr = '0; p_wdata = '0; p_wmask = '0; p_we = 1'b0;
    check("req_ready_before", req_ready, 1'b1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req_valid = 1'b0; req_store = ~st; req_funct3 = 3'b111;
      req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
      if (mem_valid) begin
        if (prev_stall && (mem_addr !== p_addr || mem_wdata !== p_wdata ||
                           mem_wmask !== p_wmask || mem_we !== p_we))
          t_unstable++;
        if (stall_left > 0) begin
          mem_ready = 1'b0; stall_left--; prev_stall = 1'b1;
          p_addr = mem_addr; p_wdata = mem_wdata; p_wmask = mem_wmask; p_we = mem_we;
        end else begin
          mem_ready = 1'b1;
          mem_rdata = (t_beats == 0) ? rd0 : rd1;
          if (t_beats < 2) begin
            t_addr[t_beats] = mem_addr; t_wdata[t_beats] = mem_wdata;
            t_wmask[t_beats] = mem_wmask; t_we[t_beats] = mem_we;
          end
          t_beats++; prev_stall = 1'b0;
        end
      end else begin
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_0000;
        prev_stall = 1'b0;
      end
      if (rsp_valid) begin
        t_rsp_cyc = k; t_err = rsp_err; t_rdata = rsp_rdata;
        break;
      end
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check("idle_after_rsp", {rsp_valid, req_ready}, 2'b01);
  endtask

  task automatic check_txn(input string name, input int e_beats, input int e_cyc,
                           input logic e_err, input logic [31:0] e_rdata);
    check({name, "_cycle"}, t_rsp_cyc, e_cyc);
    check({name, "_beats"}, t_beats, e_beats);
    check({name, "_err"}, t_err, e_err);
    check({name, "_rdata"}, t_rdata, e_rdata);
    $display("txn %s: cycle=%0d beats=%0d err=%0b rdata=0x%08h", name, t_rsp_cyc, t_beats, t_err, t_rdata);
  endtask

  initial begin
    int rsp_seen;
    int mv_seen;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
    check("rst_mem", {mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_req(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 32'h0, 0);
    check_txn("lb", 1, 2, 1'b0, 32'hFFFF_FF80);
    check("lb_addr", t_addr[0], 32'h100);
    check("lb_mask", {t_we[0], t_wmask[0]}, 5'b0_0000);

    run_req(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 32'h0, 0);
    check_txn("lbu", 1, 2, 1'b0, 32'h0000_0080);

    run_req(1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'hFFFF_FFFF, 32'h0, 0);
    check_txn("sh", 1, 2, 1'b0, 32'h0);
    check("sh_addr", t_addr[0], 32'h100);
    check("sh_mask", {t_we[0], t_wmask[0]}, 5'b1_1100);
    check("sh_wdata", t_wdata[0][31:16], 16'hABCD);

    run_req(1'b1, 3'b010, 32'h204, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 0);
    check_txn("sw", 1, 2, 1'b0, 32'h0);
    check("sw_beat", {t_addr[0], t_wdata[0], t_wmask[0]}, {32'h204, 32'h1234_5678, 4'hF});

    run_req(1'b0, 3'b001, 32'h106, 32'h0, 32'h8001_5555, 32'h0, 0);
    check_txn("lh", 1, 2, 1'b0, 32'hFFFF_8001);
    run_req(1'b0, 3'b101, 32'h106, 32'h0, 32'h8001_5555, 32'h0, 0);
    check_txn("lhu", 1, 2, 1'b0, 32'h0000_8001);

    run_req(1'b0, 3'b010, 32'h0FE, 32'h0, 32'h4433_2211, 32'h8877_6655, 0);
`ifdef MISALIGNED_SPLIT_EN
    check_txn("lw_split", 2, 3, 1'b0, 32'h6655_4433);
    check("lw_split_addrs", {t_addr[0], t_addr[1]}, {32'h0FC, 32'h100});
`else
    check_txn("lw_misal", 0, 1, 1'b1, 32'h0);
`endif

    run_req(1'b0, 3'b001, 32'h101, 32'h0, 32'h11AA_BB22, 32'h0, 0);
`ifdef MISALIGNED_SPLIT_EN
    check_txn("lh_off1", 1, 2, 1'b0, 32'hFFFF_AABB);
`else
    check_txn("lh_off1", 0, 1, 1'b1, 32'h0);
`endif

    run_req(1'b1, 3'b100, 32'h100, 32'h11, 32'h0, 32'h0, 0);
    check_txn("st_f3_100", 0, 1, 1'b1, 32'h0);
    run_req(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0, 0);
    check_txn("ld_rv32", 0, 1, 1'b1, 32'h0);
    run_req(1'b0, 3'b111, 32'h100, 32'h0, 32'h0, 32'h0, 0);
    check_txn("ld_f3_111", 0, 1, 1'b1, 32'h0);

    run_req(1'b0, 3'b010, 32'h200, 32'h0, 32'hDEAD_BEEF, 32'h0, 3);
    check_txn("lw_stall", 1, 5, 1'b0, 32'hDEAD_BEEF);
    check("lw_stall_addr", t_addr[0], 32'h200);
    check("lw_stall_unstable", t_unstable, 0);

    // Reset pulse while the first beat is pending.
    check("rst_mid_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b0;
    check("rst_mid_beat0", mem_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_async", {mem_valid, req_ready, rsp_valid}, 3'b010);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    rsp_seen = 0; mv_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
      if (mem_valid) mv_seen++;
    end
    mem_ready = 1'b0;
    check("rst_mid_no_rsp", rsp_seen, 0);
    check("rst_mid_no_beat", mv_seen, 0);
    $display("txn reset_mid_beat0: rsp_seen=%0d mem_valid_seen=%0d", rsp_seen, mv_seen);

    run_req(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 32'h0, 0);
    check_txn("lbu_after_rst", 1, 2, 1'b0, 32'h0000_0080);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
